modn_updown_counter: RTL and testbench

- Parametrised modulo-N counter built as an explicit state machine. It replaces the fixed mod-5 up counter.
- Added features: configurable modulus and width, up/down direction, count enable, synchronous load, synchronous clear, terminal-count output, and cascade carry.
- Serves as the general counting primitive for timer, divider and sequencer blocks in the same course/ASIC library.

---
 rtl/modn_updown_counter_if.sv | 26 ++
 rtl/modn_updown_counter.sv | 107 ++++++++++
 tb/tb_modn_updown_counter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/modn_updown_counter_if.sv
// Control and status bundle for the modulo-N up/down counter.
interface modn_updown_counter_if #(
   parameter int unsigned W = 3
);
   logic         CLR;
   logic         LOAD;
   logic [W-1:0] D;
   logic         EN;
   logic         UP;
   logic [W-1:0] Q;
   logic         TC;
   logic         CO;
   logic         ERR;

   // Controller side: drives commands, observes count and flags
   modport master (
      output CLR, LOAD, D, EN, UP,
      input  Q, TC, CO, ERR
   );

   // Counter side: receives commands, reports count and flags
   modport slave (
      input  CLR, LOAD, D, EN, UP,
      output Q, TC, CO, ERR
   );
endinterface

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, clear, terminal count,
// cascade carry and a sticky illegal-load flag.
module modn_updown_counter #(
   parameter int unsigned N       = 5,
   parameter int unsigned W       = 3,
   parameter int unsigned RST_VAL = 0
) (
   input logic                  CLK,
   input logic                  RST,
   modn_updown_counter_if.slave bus
);

   localparam logic [W-1:0] L_MAX = W'(N - 1);
   localparam logic [W-1:0] L_RST = W'(RST_VAL);
   localparam logic [W:0]   L_MOD = (W+1)'(N);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_COUNT    = 2'd1,
      S_HOLD_ERR = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_state_next;
   logic [W-1:0] r_q;
   logic [W-1:0] w_q_next;
   logic         r_co;
   logic         w_co_next;
   logic         r_err;
   logic         w_d_legal;
   logic         w_at_top;
   logic         w_at_zero;
   logic         w_in_range;

   // Range and boundary compares on the load data and current count
   assign w_d_legal  = ({1'b0, bus.D} < L_MOD);
   assign w_in_range = ({1'b0, r_q} < L_MOD);
   assign w_at_top   = (r_q == L_MAX);
   assign w_at_zero  = (r_q == '0);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, next-count and carry: CLR > LOAD > EN > hold
   always_comb begin
      w_state_next = bus.EN ? S_COUNT : S_IDLE;
      w_q_next     = r_q;
      w_co_next    = 1'b0;

      if (bus.CLR) begin
         w_q_next     = '0;
         w_state_next = S_IDLE;
      end else if (bus.LOAD) begin
         if (w_d_legal) begin
            w_q_next = bus.D;
         end else begin
            w_q_next     = '0;
            w_state_next = S_HOLD_ERR;
         end
      end else if (bus.EN) begin
         if (!w_in_range) begin
            // Out-of-range count (e.g. upset) recovers to zero, no carry
            w_q_next = '0;
         end else if (bus.UP) begin
            if (w_at_top) begin
               w_q_next  = '0;
               w_co_next = 1'b1;
            end else begin
               w_q_next = r_q + W'(1);
            end
         end else begin
            if (w_at_zero) begin
               w_q_next  = L_MAX;
               w_co_next = 1'b1;
            end else begin
               w_q_next = r_q - W'(1);
            end
         end
      end
   end

   // Count, carry and sticky error registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_q   <= L_RST;
         r_co  <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_q   <= w_q_next;
         r_co  <= w_co_next;
         r_err <= r_err | (r_state == S_HOLD_ERR);
      end
   end

   // ERR shows during the error-marker cycle and latches from then on
   assign bus.Q   = r_q;
   assign bus.CO  = r_co;
   assign bus.ERR = r_err | (r_state == S_HOLD_ERR);
   assign bus.TC  = bus.EN & ((bus.UP & w_at_top) | (~bus.UP & w_at_zero));

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench: five counter instances (N=5, N=5 with RST_VAL=2,
// N=16/W=4, and a two-stage N=10 cascade) against a behavioural model.
module tb_modn_updown_counter;

   logic       CLK = 1'b0;
   logic       RST;
   logic       s_clr, s_load, s_en, s_up;
   logic [3:0] s_d;

   int n_tests = 0;
   int n_fail  = 0;

   localparam int NN [5] = '{5, 5, 16, 10, 10};
   localparam int RV [5] = '{0, 2, 0, 0, 0};

   int m_q [5];
   int m_co [5];
   int m_err [5];

   always #10 CLK = ~CLK;

   modn_updown_counter_if #(.W(3)) if_a ();
   modn_updown_counter_if #(.W(3)) if_b ();
   modn_updown_counter_if #(.W(4)) if_c ();
   modn_updown_counter_if #(.W(4)) if_k0 ();
   modn_updown_counter_if #(.W(4)) if_k1 ();

   assign if_a.CLR  = s_clr;  assign if_a.LOAD = s_load; assign if_a.D  = s_d[2:0];
   assign if_a.EN   = s_en;   assign if_a.UP   = s_up;
   assign if_b.CLR  = s_clr;  assign if_b.LOAD = s_load; assign if_b.D  = s_d[2:0];
   assign if_b.EN   = s_en;   assign if_b.UP   = s_up;
   assign if_c.CLR  = s_clr;  assign if_c.LOAD = s_load; assign if_c.D  = s_d;
   assign if_c.EN   = s_en;   assign if_c.UP   = s_up;
   assign if_k0.CLR = s_clr;  assign if_k0.LOAD = 1'b0;  assign if_k0.D = 4'd0;
   assign if_k0.EN  = s_en;   assign if_k0.UP   = s_up;
   assign if_k1.CLR = s_clr;  assign if_k1.LOAD = 1'b0;  assign if_k1.D = 4'd0;
   assign if_k1.EN  = if_k0.TC; assign if_k1.UP = s_up;

   modn_updown_counter #(.N(5),  .W(3), .RST_VAL(0)) dut_a  (.CLK(CLK), .RST(RST), .bus(if_a));
   modn_updown_counter #(.N(5),  .W(3), .RST_VAL(2)) dut_b  (.CLK(CLK), .RST(RST), .bus(if_b));
   modn_updown_counter #(.N(16), .W(4), .RST_VAL(0)) dut_c  (.CLK(CLK), .RST(RST), .bus(if_c));
   modn_updown_counter #(.N(10), .W(4), .RST_VAL(0)) dut_k0 (.CLK(CLK), .RST(RST), .bus(if_k0));
   modn_updown_counter #(.N(10), .W(4), .RST_VAL(0)) dut_k1 (.CLK(CLK), .RST(RST), .bus(if_k1));

   function automatic void chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Terminal count from the rule: enabled and sitting at the end for the direction
   function automatic int tc_of(int q, int n, bit en, bit up);
      return (en && ((up && q == n - 1) || (!up && q == 0))) ? 1 : 0;
   endfunction

   function automatic bit m_en(int i);
      if (i == 4) return tc_of(m_q[3], NN[3], s_en, s_up) != 0;
      return s_en;
   endfunction

   function automatic void dut_out(int i, output int q, output int co, output int err, output int tc);
      case (i)
         0: begin q = int'(if_a.Q);  co = int'(if_a.CO);  err = int'(if_a.ERR);  tc = int'(if_a.TC);  end
         1: begin q = int'(if_b.Q);  co = int'(if_b.CO);  err = int'(if_b.ERR);  tc = int'(if_b.TC);  end
         2: begin q = int'(if_c.Q);  co = int'(if_c.CO);  err = int'(if_c.ERR);  tc = int'(if_c.TC);  end
         3: begin q = int'(if_k0.Q); co = int'(if_k0.CO); err = int'(if_k0.ERR); tc = int'(if_k0.TC); end
         default: begin q = int'(if_k1.Q); co = int'(if_k1.CO); err = int'(if_k1.ERR); tc = int'(if_k1.TC); end
      endcase
   endfunction

   // Behavioural model: modular arithmetic on plain integers
   always @(posedge CLK or posedge RST) begin
      bit en_v [5];
      if (RST) begin
         for (int i = 0; i < 5; i++) begin
            m_q[i] = RV[i]; m_co[i] = 0; m_err[i] = 0;
         end
      end else begin
         for (int i = 0; i < 5; i++) en_v[i] = m_en(i);
         for (int i = 0; i < 5; i++) begin
            int  n, d, q;
            bit  ld;
            n  = NN[i];
            q  = m_q[i];
            ld = (i < 3) ? s_load : 1'b0;
            d  = (i < 2) ? int'(s_d[2:0]) : ((i == 2) ? int'(s_d) : 0);
            m_co[i] = 0;
            if (s_clr) begin
               m_q[i] = 0;
            end else if (ld) begin
               if (d < n) m_q[i] = d;
               else begin m_q[i] = 0; m_err[i] = 1; end
            end else if (en_v[i]) begin
               if (q >= n) m_q[i] = 0;
               else if (s_up) begin
                  m_q[i] = (q + 1) % n;
                  m_co[i] = (q == n - 1) ? 1 : 0;
               end else begin
                  m_q[i] = (q + n - 1) % n;
                  m_co[i] = (q == 0) ? 1 : 0;
               end
            end
         end
      end
   end

   // Per-cycle comparison of all instances against the model
   always @(negedge CLK) begin
      if (!RST) begin
         for (int i = 0; i < 5; i++) begin
            int q, co, err, tc;
            dut_out(i, q, co, err, tc);
            chk($sformatf("q%0d", i),   q,   m_q[i]);
            chk($sformatf("co%0d", i),  co,  m_co[i]);
            chk($sformatf("err%0d", i), err, m_err[i]);
            chk($sformatf("tc%0d", i),  tc,  tc_of(m_q[i], NN[i], m_en(i), s_up));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      #2;
   endtask

   // Asynchronous reset pulse placed between clock edges
   task automatic rst_pulse_check();
      #1 RST = 1'b1;
      #1;
      chk("rst_async_a", int'(if_a.Q), 0);
      chk("rst_async_b", int'(if_b.Q), 2);
      chk("rst_async_err", int'(if_a.ERR), 0);
      #1 RST = 1'b0;
   endtask

   int exp_up [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
   int exp_dn [6]  = '{4, 3, 2, 1, 0, 4};

   initial begin
      s_clr = 1'b0; s_load = 1'b0; s_en = 1'b0; s_up = 1'b1; s_d = 4'd0;
      RST = 1'b0;
      #1 RST = 1'b1;
      #1;
      chk("reset_q_a", int'(if_a.Q), 0);
      chk("reset_q_b", int'(if_b.Q), 2);
      chk("reset_co",  int'(if_a.CO), 0);
      chk("reset_err", int'(if_a.ERR), 0);
      @(negedge CLK);
      #2 RST = 1'b0;

      // Up count from reset
      s_en = 1'b1; s_up = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("lit_up_q",  int'(if_a.Q), exp_up[k]);
         chk("lit_up_co", int'(if_a.CO), (k == 4 || k == 9) ? 1 : 0);
         chk("mdl_up_q",  m_q[0], exp_up[k]);
      end

      // Down count from zero
      s_clr = 1'b1; tick();
      s_clr = 1'b0; s_up = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("lit_dn_q",  int'(if_a.Q), exp_dn[k]);
         chk("lit_dn_co", int'(if_a.CO), (k == 0 || k == 5) ? 1 : 0);
      end

      // Legal load then count, illegal load, clear keeps ERR
      s_up = 1'b1; s_load = 1'b1; s_d = 4'd3; tick();
      chk("lit_load3", int'(if_a.Q), 3);
      s_load = 1'b0; tick();
      chk("lit_load_cnt1", int'(if_a.Q), 4);
      tick();
      chk("lit_load_cnt2", int'(if_a.Q), 0);
      chk("lit_load_co",   int'(if_a.CO), 1);
      s_load = 1'b1; s_d = 4'd6; tick();
      chk("lit_bad_q",   int'(if_a.Q), 0);
      chk("lit_bad_err", int'(if_a.ERR), 1);
      chk("lit_c_load6", int'(if_c.Q), 6);
      s_load = 1'b0; s_clr = 1'b1; tick();
      chk("lit_err_sticky", int'(if_a.ERR), 1);

      // CLR beats LOAD and EN; then hold
      s_clr = 1'b0; s_load = 1'b1; s_d = 4'd2; s_en = 1'b0; tick();
      chk("lit_load2", int'(if_a.Q), 2);
      s_clr = 1'b1; s_load = 1'b1; s_en = 1'b1; s_d = 4'd3; tick();
      chk("lit_clr_prio", int'(if_a.Q), 0);
      s_clr = 1'b0; s_load = 1'b0; s_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lit_hold_q",  int'(if_a.Q), 0);
         chk("lit_hold_co", int'(if_a.CO), 0);
      end

      // Reset between edges, then cascade and N=16 wrap
      s_load = 1'b1; s_d = 4'd3; tick();
      chk("lit_pre_rst", int'(if_a.Q), 3);
      s_load = 1'b0;
      rst_pulse_check();
      s_en = 1'b1; s_up = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick();
         if (k == 1) begin
            chk("lit_rstval_first", int'(if_b.Q), 3);
            chk("lit_a_first",      int'(if_a.Q), 1);
         end
         if (k == 16) begin
            chk("lit_c_wrap_q",  int'(if_c.Q), 0);
            chk("lit_c_wrap_co", int'(if_c.CO), 1);
         end
      end
      chk("lit_casc_s1", int'(if_k1.Q), 2);
      chk("lit_casc_s0", int'(if_k0.Q), 5);
      chk("mdl_casc_s1", m_q[4], 2);

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         s_clr  = ($urandom_range(0, 15) == 0);
         s_load = ($urandom_range(0, 7) == 0);
         s_d    = 4'($urandom);
         s_en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) s_up = ~s_up;
         tick();
         if (k == 200) rst_pulse_check();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
